// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package div_pkg;

  localparam int N_DVD_DEF = 8;
  localparam int N_DVS_DEF = 4;
  localparam int CNT_W_DEF = $clog2(N_DVD_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CALC = 2'b10
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int N_DVS = 4
) (
  input  logic [N_DVS:0]   r_i,
  input  logic             msb_i,
  input  logic [N_DVS-1:0] d_i,
  output logic [N_DVS:0]   r_o,
  output logic             q_o
);

  logic [N_DVS:0]   rs;
  logic [N_DVS+1:0] t;
  // R's top bit is always shifted out; R < D keeps it zero for any nonzero divisor.
  logic             unused_r_msb;

  assign unused_r_msb = r_i[N_DVS];
  assign rs  = {r_i[N_DVS-1:0], msb_i};
  assign t   = {1'b0, rs} - {2'b00, d_i};
  assign q_o = ~t[N_DVS+1];
  assign r_o = q_o ? t[N_DVS:0] : rs;

endmodule

// File: rtl/div8x4.sv
// Sequential unsigned restoring divider, one quotient bit per clock, level start / done-in-IDLE.
// Define DIV_ZERO_SKIP_EN to bypass CALC when the captured divisor is zero.
module div8x4
  import div_pkg::*;
#(
  parameter int N_DVD = N_DVD_DEF,
  parameter int N_DVS = N_DVS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_DVD-1:0] dividend,
  input  logic [N_DVS-1:0] divisor,
  output logic [N_DVD-1:0] quotient,
  output logic [N_DVS-1:0] remainder,
  output logic             div_by_zero,
  output logic             done
);

  localparam int CNT_W = $clog2(N_DVD + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_DVD - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_DVD-1:0] q_q;
  logic [N_DVD-1:0] q_d;
  logic [N_DVS:0]   r_q;
  logic [N_DVS:0]   r_d;
  logic [N_DVS-1:0] d_q;
  logic             dz_q;
  logic             qbit;

  div_step #(.N_DVS(N_DVS)) u_step (
    .r_i   (r_q),
    .msb_i (q_q[N_DVD-1]),
    .d_i   (d_q),
    .r_o   (r_d),
    .q_o   (qbit)
  );

  assign q_d = {q_q[N_DVD-2:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      dz_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            done    <= 1'b0;
          end
        end
        LOAD: begin
          q_q   <= dividend;
          d_q   <= divisor;
          r_q   <= '0;
          cnt_q <= '0;
          dz_q  <= (divisor == '0);
`ifdef DIV_ZERO_SKIP_EN
          if (divisor == '0) begin
            state_q     <= IDLE;
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
          end else begin
            state_q <= CALC;
          end
`else
          state_q <= CALC;
`endif
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= IDLE;
            done    <= 1'b1;
            // A zero divisor still runs the full loop; its result is replaced here.
            if (dz_q) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= q_d;
              remainder   <= r_d[N_DVS-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8x4.sv
// Scoreboard bench for div8x4: driver pushes expected results, monitor pops on each done rise.
module tb_div8x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       done;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         issue;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic ignore_rise = 1'b0;
  logic prev_done   = 1'b1;

`ifdef DIV_ZERO_SKIP_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 10;
`endif

  div8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] q, input logic [3:0] r, input logic dz, input int issue);
    exp_t e;
    e.q     = q;
    e.r     = r;
    e.dz    = dz;
    e.issue = issue;
    e.lat   = dz ? ZLAT : 10;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle, keep operands through the LOAD edge, then scramble them.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r, input logic dz);
    int t;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    push_exp(q, r, dz, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = ~a;
    divisor  = ~b;
    t = 0;
    while (!done && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  // Monitor: compare result and latency on every rising edge of done.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1 && prev_done === 1'b0) begin
      if (ignore_rise) begin
        ignore_rise = 1'b0;
      end else if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("[TB] op issue=%0d q=%0d r=%0d dz=%0d lat=%0d", e.issue, quotient, remainder,
                 div_by_zero, cyc - e.issue + 1);
        chk("result", {19'd0, quotient, remainder, div_by_zero}, {19'd0, e.q, e.r, e.dz});
        chk("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
      end
    end
    prev_done = done;
  end

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t b2b[3];

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {19'd0, quotient, remainder, div_by_zero, done}, 32'd1);

    run_op(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    run_op(8'd7,   4'd9,  8'd0,  4'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_7_9", {20'd0, quotient, remainder}, {20'd0, 8'd0, 4'd7});
    run_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0);
    run_op(8'd24,  4'd3,  8'd8,   4'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_24_3", {20'd0, quotient, remainder}, {20'd0, 8'd8, 4'd0});
    run_op(8'd100, 4'd0,  8'hFF, 4'd0, 1'b1);

    // Reset during the 4th CALC cycle of 200/13.
    @(negedge clk);
    dividend    = 8'd200;
    divisor     = 4'd13;
    start       = 1'b1;
    ignore_rise = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset", {19'd0, quotient, remainder, div_by_zero, done}, 32'd1);
    run_op(8'd66, 4'd11, 8'd6, 4'd0, 1'b0);

    // Back-to-back with start held high and operands churning outside each LOAD edge.
    b2b[0] = '{a: 8'd50,  b: 4'd7,  q: 8'd7,  r: 4'd1};
    b2b[1] = '{a: 8'd143, b: 4'd12, q: 8'd11, r: 4'd11};
    b2b[2] = '{a: 8'd9,   b: 4'd2,  q: 8'd4,  r: 4'd1};
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    push_exp(b2b[0].q, b2b[0].r, 1'b0, cyc + 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      dividend = b2b[k].a;
      divisor  = b2b[k].b;
      @(posedge clk);
      @(negedge clk);
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      if (k == 2) begin
        start = 1'b0;
      end else begin
        push_exp(b2b[k+1].q, b2b[k+1].r, 1'b0, cyc + 9);
        repeat (8) begin
          @(negedge clk);
          dividend = 8'($urandom);
          divisor  = 4'($urandom);
        end
      end
    end
    repeat (12) @(negedge clk);
    chk("b2b_final_done", 32'(done), 32'd1);

    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_op(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
